// File: rtl/mem_access.sv
// Memory-access stage: runs one request/response transaction with the data
// memory for each LW/SW and stalls the core until the transaction completes.
//
// state | meaning
// IDLE  | nothing outstanding; non-memory ops pass Result straight through
// REQ   | DM_req held with stable address/data until DM_ready
// WAIT  | load accepted, waiting for DM_rvalid
// DONE  | Stall released for one cycle with the writeback value
module mem_access #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic [31:0] Wdata,
    output logic        DM_req,
    output logic        DM_we,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_wdata,
    input  logic        DM_ready,
    input  logic        DM_rvalid,
    input  logic [31:0] DM_rdata,
    output logic        Err
);

    localparam logic [5:0]       OP_LW    = 6'h23;
    localparam logic [5:0]       OP_SW    = 6'h2B;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      ld_data, ld_data_nxt;
    logic             req_nxt, we_nxt, err_nxt;
    logic [31:0]      addr_nxt, wdata_nxt;
    logic [5:0]       opcode;
    logic             is_lw, is_sw, is_mem, timeout;
    logic             unused_ins;

    assign opcode     = Ins[31:26];
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_mem     = is_lw | is_sw;
    assign timeout    = (cnt == CNT_LAST);
    assign unused_ins = ^Ins[25:0];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            ld_data  <= '0;
            DM_req   <= 1'b0;
            DM_we    <= 1'b0;
            DM_addr  <= '0;
            DM_wdata <= '0;
            Err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ld_data  <= ld_data_nxt;
            DM_req   <= req_nxt;
            DM_we    <= we_nxt;
            DM_addr  <= addr_nxt;
            DM_wdata <= wdata_nxt;
            Err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ld_data_nxt = ld_data;
        req_nxt     = DM_req;
        we_nxt      = DM_we;
        addr_nxt    = DM_addr;
        wdata_nxt   = DM_wdata;
        err_nxt     = Err;
        Stall       = 1'b0;
        Wdata       = Result;

        case (state)
            IDLE: begin
                if (is_mem) begin
                    Stall = 1'b1;
                    if (Result[1:0] != 2'b00) begin
                        err_nxt     = 1'b1;
                        ld_data_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        addr_nxt  = Result;
                        we_nxt    = is_sw;
                        wdata_nxt = Rdata2;
                        req_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                // an accept on the timeout cycle still counts as a success
                if (DM_ready) begin
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = DM_we ? DONE : WAIT;
                end else if (timeout) begin
                    req_nxt     = 1'b0;
                    err_nxt     = 1'b1;
                    ld_data_nxt = '0;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (DM_rvalid) begin
                    ld_data_nxt = DM_rdata;
                    state_nxt   = DONE;
                end else if (timeout) begin
                    err_nxt     = 1'b1;
                    ld_data_nxt = '0;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                // Ins is still held by the core here, so it selects the source
                Wdata     = is_lw ? ld_data : Result;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// accesses compared against a transaction-level model of stall/request counts.
module tb_mem_access;

    localparam int         TO    = 4;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    logic        CLK       = 1'b0;
    logic        RST       = 1'b0;
    logic [31:0] Ins       = '0;
    logic [31:0] Result    = '0;
    logic [31:0] Rdata2    = '0;
    logic        DM_ready  = 1'b0;
    logic        DM_rvalid = 1'b0;
    logic [31:0] DM_rdata  = '0;
    logic        Stall;
    logic [31:0] Wdata;
    logic        DM_req;
    logic        DM_we;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic        Err;

    int   checks    = 0;
    int   failures  = 0;
    logic err_model = 1'b0;

    mem_access #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .Stall(Stall), .Wdata(Wdata), .DM_req(DM_req), .DM_we(DM_we),
        .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_ready(DM_ready),
        .DM_rvalid(DM_rvalid), .DM_rdata(DM_rdata), .Err(Err)
    );

    always #5 CLK = ~CLK;

    // Reference: outcome of one access from the opcode, alignment and memory delays.
    function automatic void exp_access(input logic [31:0] ins, input logic [31:0] res,
                                       input logic [31:0] rd, input int rdy_dly, input int rv_dly,
                                       output int e_stall, output int e_req,
                                       output logic [31:0] e_wd, output logic e_err);
        logic [5:0] op;
        op      = ins[31:26];
        e_stall = 0;
        e_req   = 0;
        e_wd    = res;
        e_err   = 1'b0;
        if (op != OP_LW && op != OP_SW) return;
        if (res[1:0] != 2'b00) begin
            e_stall = 1;
            e_err   = 1'b1;
            if (op == OP_LW) e_wd = '0;
            return;
        end
        if (rdy_dly >= TO) begin
            e_req   = TO;
            e_stall = 1 + TO;
            e_err   = 1'b1;
            if (op == OP_LW) e_wd = '0;
            return;
        end
        e_req   = rdy_dly + 1;
        e_stall = 1 + e_req;
        if (op == OP_SW) return;
        if (rv_dly >= TO) begin
            e_stall += TO;
            e_err    = 1'b1;
            e_wd     = '0;
        end else begin
            e_stall += rv_dly + 1;
            e_wd     = rd;
        end
    endfunction

    // Plays the core and the memory for one instruction; starts and ends at a negedge.
    task automatic run_access(input logic [31:0] ins, input logic [31:0] res,
                              input logic [31:0] d2, input int rdy_dly, input int rv_dly,
                              input logic [31:0] rd, output int n_stall, output int n_req,
                              output logic [31:0] wd, output logic hold_ok);
        int          req_lo;
        int          wait_lo;
        bit          in_wait;
        bit          done;
        bit          ld;
        bit          st;
        logic [31:0] junk;
        req_lo  = 0;
        wait_lo = 0;
        in_wait = 1'b0;
        done    = 1'b0;
        ld      = (ins[31:26] == OP_LW);
        st      = (ins[31:26] == OP_SW);
        n_stall = 0;
        n_req   = 0;
        wd      = '0;
        hold_ok = 1'b1;
        Ins     = ins;
        Result  = res;
        Rdata2  = d2;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            DM_ready  = DM_req && (req_lo == rdy_dly);
            DM_rvalid = in_wait && (wait_lo == rv_dly);
            junk      = $urandom();
            DM_rdata  = DM_rvalid ? rd : junk;
            #1;
            if (!Stall) begin
                done = 1'b1;
                wd   = Wdata;
            end else begin
                n_stall++;
            end
            if (DM_req) begin
                n_req++;
                if (DM_addr !== res || DM_we !== st || DM_wdata !== d2) hold_ok = 1'b0;
                if (DM_ready) in_wait = ld;
                else req_lo++;
            end else if (in_wait) begin
                if (DM_rvalid) in_wait = 1'b0;
                else wait_lo++;
            end
            @(negedge CLK);
        end
        Ins       = '0;
        DM_ready  = 1'b0;
        DM_rvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_bound: no Stall release within 300 cycles, ins=%h", ins);
        end
    endtask

    task automatic do_reset(input int n);
        RST       = 1'b0;
        Ins       = '0;
        DM_ready  = 1'b0;
        DM_rvalid = 1'b0;
        repeat (n) @(negedge CLK);
        RST       = 1'b1;
        err_model = 1'b0;
    endtask

    task automatic test_reset();
        int          n_stall, n_req;
        logic [31:0] wd;
        logic        hold_ok;
        RST    = 1'b0;
        Ins    = {OP_LW, 26'h0};
        Result = 32'h40;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (DM_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", DM_req); end
        checks++; if (Err !== 1'b0)    begin failures++; $display("FAIL rst_err got=%b exp=0", Err); end
        checks++; if (Stall !== 1'b1)  begin failures++; $display("FAIL rst_stall got=%b exp=1", Stall); end
        RST = 1'b1;
        run_access({OP_LW, 26'h0}, 32'h40, 32'h0, 0, 0, 32'h11223344, n_stall, n_req, wd, hold_ok);
        checks++; if (n_stall != 3) begin failures++; $display("FAIL rst_lw_stall got=%0d exp=3", n_stall); end
        checks++; if (wd !== 32'h11223344) begin failures++; $display("FAIL rst_lw_wdata got=%h exp=11223344", wd); end
        // reset while a request is outstanding
        Ins    = {OP_LW, 26'h0};
        Result = 32'h80;
        @(negedge CLK);
        #1;
        checks++; if (DM_req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req got=%b exp=1", DM_req); end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if (DM_req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", DM_req); end
        RST = 1'b1;
        Ins = '0;
        @(negedge CLK);
    endtask

    task automatic test_passthrough();
        Ins    = {6'h00, 26'h0};
        Result = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (Stall !== 1'b0)       begin failures++; $display("FAIL pass_stall got=%b exp=0", Stall); end
            checks++; if (Wdata !== 32'h1234)   begin failures++; $display("FAIL pass_wdata got=%h exp=00001234", Wdata); end
            checks++; if (DM_req !== 1'b0)      begin failures++; $display("FAIL pass_req got=%b exp=0", DM_req); end
            @(negedge CLK);
        end
    endtask

    task automatic test_sw();
        int          n_stall, n_req;
        logic [31:0] wd;
        logic        hold_ok;
        run_access({OP_SW, 26'h0}, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, n_stall, n_req, wd, hold_ok);
        checks++; if (n_stall != 2)     begin failures++; $display("FAIL sw_stall got=%0d exp=2", n_stall); end
        checks++; if (n_req != 1)       begin failures++; $display("FAIL sw_req got=%0d exp=1", n_req); end
        checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL sw_fields got=%b exp=1", hold_ok); end
        checks++; if (wd !== 32'h100)   begin failures++; $display("FAIL sw_wdata got=%h exp=00000100", wd); end
        checks++; if (Err !== 1'b0)     begin failures++; $display("FAIL sw_err got=%b exp=0", Err); end
    endtask

    task automatic test_lw_backpressure();
        int          n_stall, n_req;
        logic [31:0] wd;
        logic        hold_ok;
        Ins       = '0;
        DM_rvalid = 1'b1;
        DM_rdata  = 32'hBAD0BAD0;
        @(negedge CLK);
        DM_rvalid = 1'b0;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL idle_rvalid_stall got=%b exp=0", Stall); end
        run_access({OP_LW, 26'h0}, 32'h200, 32'h0, 3, 1, 32'hCAFEF00D, n_stall, n_req, wd, hold_ok);
        checks++; if (n_stall != 7)        begin failures++; $display("FAIL lw_bp_stall got=%0d exp=7", n_stall); end
        checks++; if (n_req != 4)          begin failures++; $display("FAIL lw_bp_req got=%0d exp=4", n_req); end
        checks++; if (hold_ok !== 1'b1)    begin failures++; $display("FAIL lw_bp_addr_stable got=%b exp=1", hold_ok); end
        checks++; if (wd !== 32'hCAFEF00D) begin failures++; $display("FAIL lw_bp_wdata got=%h exp=cafef00d", wd); end
    endtask

    task automatic test_misaligned();
        int          n_stall, n_req;
        logic [31:0] wd;
        logic        hold_ok;
        run_access({OP_LW, 26'h0}, 32'h102, 32'h0, 0, 0, 32'h55555555, n_stall, n_req, wd, hold_ok);
        err_model = 1'b1;
        checks++; if (n_stall != 1) begin failures++; $display("FAIL mis_stall got=%0d exp=1", n_stall); end
        checks++; if (n_req != 0)   begin failures++; $display("FAIL mis_req got=%0d exp=0", n_req); end
        checks++; if (wd !== 32'h0) begin failures++; $display("FAIL mis_wdata got=%h exp=0", wd); end
        checks++; if (Err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", Err); end
    endtask

    task automatic test_timeout();
        int          n_stall, n_req;
        logic [31:0] wd;
        logic        hold_ok;
        do_reset(2);
        run_access({OP_LW, 26'h0}, 32'h300, 32'h0, 100, 0, 32'h0, n_stall, n_req, wd, hold_ok);
        checks++; if (n_req != TO)       begin failures++; $display("FAIL to_req got=%0d exp=%0d", n_req, TO); end
        checks++; if (n_stall != TO + 1) begin failures++; $display("FAIL to_stall got=%0d exp=%0d", n_stall, TO + 1); end
        checks++; if (Err !== 1'b1)      begin failures++; $display("FAIL to_err got=%b exp=1", Err); end
        checks++; if (wd !== 32'h0)      begin failures++; $display("FAIL to_wdata got=%h exp=0", wd); end
        do_reset(2);
        run_access({OP_SW, 26'h0}, 32'h304, 32'h0BADCAFE, TO - 1, 0, 32'h0, n_stall, n_req, wd, hold_ok);
        checks++; if (n_req != TO)       begin failures++; $display("FAIL to_edge_req got=%0d exp=%0d", n_req, TO); end
        checks++; if (n_stall != TO + 1) begin failures++; $display("FAIL to_edge_stall got=%0d exp=%0d", n_stall, TO + 1); end
        checks++; if (Err !== 1'b0)      begin failures++; $display("FAIL to_edge_err got=%b exp=0", Err); end
    endtask

    task automatic test_random();
        int          n_stall, n_req, e_stall, e_req, rdy_dly, rv_dly;
        logic [31:0] wd, e_wd, r0, r1, r2, r3, ins, res;
        logic        hold_ok, e_err;
        logic [5:0]  op;
        do_reset(2);
        for (int t = 0; t < 40; t++) begin
            r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
            case ($urandom_range(0, 2))
                0:       op = OP_LW;
                1:       op = OP_SW;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (op == OP_LW || op == OP_SW) op = 6'h00;
                end
            endcase
            ins     = {op, r0[25:0]};
            res     = ($urandom_range(0, 4) == 0) ? r1 : {r1[31:2], 2'b00};
            rdy_dly = $urandom_range(0, 5);
            rv_dly  = $urandom_range(0, 5);
            exp_access(ins, res, r3, rdy_dly, rv_dly, e_stall, e_req, e_wd, e_err);
            run_access(ins, res, r2, rdy_dly, rv_dly, r3, n_stall, n_req, wd, hold_ok);
            err_model = err_model | e_err;
            checks++; if (n_stall != e_stall) begin failures++; $display("FAIL rnd_stall t=%0d got=%0d exp=%0d", t, n_stall, e_stall); end
            checks++; if (n_req != e_req)     begin failures++; $display("FAIL rnd_req t=%0d got=%0d exp=%0d", t, n_req, e_req); end
            checks++; if (wd !== e_wd)        begin failures++; $display("FAIL rnd_wdata t=%0d got=%h exp=%h", t, wd, e_wd); end
            checks++; if (hold_ok !== 1'b1)   begin failures++; $display("FAIL rnd_fields t=%0d got=%b exp=1", t, hold_ok); end
            checks++; if (Err !== err_model)  begin failures++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, Err, err_model); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_sw();
        test_lw_backpressure();
        test_misaligned();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage behind the execute stage of the MIPS core.
- Consumes the instruction word, the execute-stage Result (ALU value, or effective address for LW/SW) and Rdata2 (store data).
- Runs a multi-cycle request/response transaction with an external data memory and stalls the core while an access is outstanding.
- Presents the writeback value: load data for LW, Result for everything else.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ or WAIT before the access is abandoned; minimum value 1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-low.
- Ins  in  32  current instruction; opcode is Ins[31:26].
- Result  in  32  execute-stage result or effective address.
- Rdata2  in  32  store data for SW.
- Stall  out  1  high = core must hold PC/instruction this cycle.
- Wdata  out  32  writeback value; meaningful when Stall=0.
- DM_req  out  1  request valid to data memory.
- DM_we  out  1  1 = write (SW), 0 = read (LW); meaningful when DM_req=1.
- DM_addr  out  32  word-aligned byte address.
- DM_wdata  out  32  store data.
- DM_ready  in  1  memory accepts the request; handshake completes on a cycle with DM_req & DM_ready.
- DM_rvalid  in  1  read data valid.
- DM_rdata  in  32  read data.
- Err  out  1  sticky error flag: misaligned address or timeout.

Behaviour:
- Opcodes: LW = 6'h23, SW = 6'h2B. Every other opcode is a non-memory instruction.
- States: IDLE, REQ, WAIT, DONE.
- Reset (RST=0 at a clock edge): state=IDLE. DM_req, DM_we, DM_addr, DM_wdata, Err, captured load data and counter all go to 0. A transaction in flight is abandoned and DM_req is low from the next cycle.
- IDLE, non-memory Ins: Stall=0 and Wdata=Result, both combinational; state stays IDLE.
- IDLE, LW/SW: Stall=1 combinationally.
  - Result[1:0]!=0: Err<=1, captured data<=0, next state DONE; no request issued.
  - Otherwise: register DM_addr<=Result, DM_we<=(SW), DM_wdata<=Rdata2, DM_req<=1, counter<=0; next state REQ.
- REQ: Stall=1; DM_req, DM_addr, DM_we and DM_wdata are held stable until accepted.
  - Accept (DM_ready=1): DM_req<=0, counter<=0; next state DONE for SW, WAIT for LW.
  - No accept and counter==TIMEOUT-1: DM_req<=0, Err<=1, captured data<=0; next state DONE.
  - Otherwise counter increments.
- WAIT: Stall=1.
  - DM_rvalid=1: captured data<=DM_rdata; next state DONE.
  - Timeout: same rule as REQ (Err<=1, captured data<=0, DONE).
- DM_rvalid outside WAIT is ignored.
- DONE: Stall=0 for exactly one cycle. Wdata=captured data for LW, Result for SW. Next state is IDLE unconditionally, because the core advances at this edge.
- Minimum stall cycles with zero-wait memory: SW = 2 (IDLE, REQ); LW = 3 (IDLE, REQ, WAIT).
- Err stays set until reset. Once set, later accesses still execute normally.
- DM_ready on the same edge as the timeout: accept wins, no error.

Test Plan:
- Reset: RST=0 for 2 cycles with Ins=LW -> DM_req=0, Err=0, Stall=1 combinationally (IDLE with a memory op); after release the access proceeds normally.
- Non-memory pass-through: Ins opcode 6'h00, Result=32'h1234 -> Stall=0, Wdata=32'h1234, DM_req never asserted.
- SW, DM_ready held high: Result=32'h100, Rdata2=32'hDEADBEEF -> DM_req=1 with DM_we=1, DM_addr=32'h100, DM_wdata=32'hDEADBEEF for 1 cycle; Stall high for 2 cycles, then 1 cycle low.
- LW with backpressure: DM_ready low for 3 cycles, then DM_rvalid 2 cycles after accept with DM_rdata=32'hCAFEF00D -> DM_addr stable throughout REQ; in DONE Wdata=32'hCAFEF00D and Stall=0; DM_rvalid pulsed during IDLE is ignored.
- Misaligned LW, Result=32'h102 -> no DM_req, Err=1, DONE with Wdata=0 after 1 stall cycle.
- Timeout with TIMEOUT=4: DM_ready never asserted -> DM_req high for exactly 4 cycles, then Err=1 and DONE. Second run with DM_ready asserted on the 4th REQ cycle -> accepted, Err stays 0.
